// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: valid/ready handshake with a two-entry
// skid buffer, synchronous flush, occupancy report and a saturating stall counter.
module pipe_stage_elastic #(
    parameter int              W           = 140,
    parameter logic [W-1:0]    BUBBLE      = '0,
    parameter bit              ZERO_BUBBLE = 1'b1,
    parameter int              CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             stall_clr
);

    typedef enum logic [1:0] {
        EMPTY,
        BUSY,
        FULL
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   main_data;
    logic [W-1:0]   skid_data;
    logic           main_valid;
    logic           skid_valid;
    logic           push;
    logic           pop;
    logic           load_main;
    logic           main_from_skid;
    logic           load_skid;

    // Valids are decoded from the state so skid_valid can never be set without main_valid.
    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == FULL);

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign push      = in_valid & in_ready;
    assign pop       = main_valid & out_ready;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
    assign out_data  = (ZERO_BUBBLE && !main_valid) ? BUBBLE : main_data;

    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    load_main  = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (push && pop) begin
                    load_main = 1'b1;
                end else if (push) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_next     = BUSY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state     <= EMPTY;
            main_data <= BUBBLE;
            skid_data <= BUBBLE;
        end else begin
            state <= state_next;
            if (load_main) begin
                main_data <= main_from_skid ? skid_data : in_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

    // Counts upstream stall cycles; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (rst || stall_clr) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed scenarios plus a
// randomized run, all compared against a queue-based model of the stage.
module tb_pipe_stage_elastic;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] occupancy;
    logic [3:0] stall_cnt;
    logic       stall_clr = 1'b0;

    int checks = 0;
    int fails  = 0;

    logic [7:0] mq[$];
    int         mcnt = 0;

    pipe_stage_elastic #(
        .W(8),
        .BUBBLE(8'h00),
        .ZERO_BUBBLE(1'b1),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt),
        .stall_clr(stall_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_data();
        return (mq.size() > 0) ? mq[0] : 8'h00;
    endfunction

    function automatic logic [1:0] exp_occ();
        return 2'(mq.size());
    endfunction

    // Stage modelled as a FIFO of depth two; ready is simply "fewer than two held".
    task automatic tick(input logic v, input logic [7:0] d, input logic ordy,
                        input logic fl, input logic r, input logic clr);
        bit can_push;
        bit can_pop;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        stall_clr = clr;
        @(posedge clk);
        if (r) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (clr) mcnt = 0;
            else if (v && mq.size() == 2 && mcnt < 15) mcnt = mcnt + 1;
            if (fl) begin
                mq.delete();
            end else begin
                can_push = v && (mq.size() < 2);
                can_pop  = (mq.size() > 0) && ordy;
                if (can_pop) void'(mq.pop_front());
                if (can_push) mq.push_back(d);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (occupancy !== 2'd0) begin fails++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy); end
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (out_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_out_data: got %h expected 00", out_data); end
        checks++;
        if (stall_cnt !== 4'd0) begin fails++; $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_stream();
        logic [7:0] vals[3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, vals[i], 1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (out_data !== vals[i] || out_valid !== 1'b1) begin
                fails++;
                $display("[TB] FAIL stream_data[%0d]: got %h/%b expected %h/1", i, out_data, out_valid, vals[i]);
            end
            checks++;
            if (in_ready !== 1'b1 || occupancy !== 2'd1) begin
                fails++;
                $display("[TB] FAIL stream_ready_occ[%0d]: got %b/%0d expected 1/1", i, in_ready, occupancy);
            end
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL stream_drain: got out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] got[$];
        logic [7:0] want[3] = '{8'hA1, 8'hA2, 8'hA3};
        bit sent = 1'b0;
        bit accept;
        tick(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (occupancy !== 2'd1) begin fails++; $display("[TB] FAIL bp_occ1: got %0d expected 1", occupancy); end
        tick(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_full: got occ %0d ready %b expected 2/0", occupancy, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (stall_cnt !== 4'(i + 1)) begin
                fails++;
                $display("[TB] FAIL bp_stall_cnt[%0d]: got %0d expected %0d", i, stall_cnt, i + 1);
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (out_valid) got.push_back(out_data);
            accept = !sent && in_ready;
            tick(!sent, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0);
            if (accept) sent = 1'b1;
        end
        checks++;
        if (got.size() != 3) begin
            fails++;
            $display("[TB] FAIL bp_count: got %0d bundles expected 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== want[i]) begin
                    fails++;
                    $display("[TB] FAIL bp_order[%0d]: got %h expected %h", i, got[i], want[i]);
                end
            end
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        tick(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'hB3, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL flush_full: got v%b occ%0d d%h rdy%b expected v0 occ0 d00 rdy1",
                     out_valid, occupancy, out_data, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b0 || out_data === 8'hB3) begin
                fails++;
                $display("[TB] FAIL flush_no_b3[%0d]: got v%b d%h expected v0 d00", i, out_valid, out_data);
            end
        end
        tick(1'b1, 8'hB4, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'hB5, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL flush_busy: got occ %0d v %b expected 0/0", occupancy, out_valid);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_push_pop();
        tick(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'hC2, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_data !== 8'hC2 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL push_pop: got d%h occ%0d rdy%b expected dC2 occ1 rdy1", out_data, occupancy, in_ready);
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'hE2, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 8'hE3, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (stall_cnt !== 4'(mcnt)) begin
                fails++;
                $display("[TB] FAIL sat_step[%0d]: got %0d expected %0d", i, stall_cnt, mcnt);
            end
        end
        checks++;
        if (stall_cnt !== 4'd15) begin fails++; $display("[TB] FAIL sat_max: got %0d expected 15", stall_cnt); end
        tick(1'b1, 8'hE3, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (stall_cnt !== 4'd0) begin fails++; $display("[TB] FAIL sat_clr: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_rst_flush();
        tick(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 ||
            out_data !== 8'h00 || stall_cnt !== 4'd0) begin
            fails++;
            $display("[TB] FAIL rst_flush: got v%b occ%0d rdy%b d%h cnt%0d expected v0 occ0 rdy1 d00 cnt0",
                     out_valid, occupancy, in_ready, out_data, stall_cnt);
        end
        tick(1'b1, 8'hD1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hD1) begin
            fails++;
            $display("[TB] FAIL rst_resume: got v%b d%h expected v1 dD1", out_valid, out_data);
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 31) == 0));
            checks++;
            if (out_valid !== (mq.size() > 0) || out_data !== exp_data() ||
                occupancy !== exp_occ() || in_ready !== (mq.size() < 2) ||
                stall_cnt !== 4'(mcnt)) begin
                fails++;
                $display("[TB] FAIL random[%0d]: got v%b d%h occ%0d rdy%b cnt%0d expected v%b d%h occ%0d rdy%b cnt%0d",
                         i, out_valid, out_data, occupancy, in_ready, stall_cnt,
                         mq.size() > 0, exp_data(), exp_occ(), mq.size() < 2, mcnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_push_pop();
        test_saturation();
        test_rst_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed-width, enable-only pipeline-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Sits between two pipeline stages. It carries a W-bit stage bundle using a valid/ready handshake, so backpressure stalls upstream without losing data.
- Has a 2-entry skid buffer (main + skid) for full throughput with registered ready, synchronous flush for branch/exception squash, bubble insertion, occupancy output and a stall counter.

Parameters:
- W, 140, width of the stage bundle.
- BUBBLE, {W{1'b0}}, value loaded into data registers on reset/flush; value driven on out_data when out_valid=0 and ZERO_BUBBLE=1.
- ZERO_BUBBLE, 1, 1: out_data=BUBBLE whenever out_valid=0; 0: out_data holds the main register contents.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  squash all held entries (synchronous).
- in_valid  input  1  upstream bundle valid.
- in_ready  output  1  stage can accept; registered, equals !skid_valid.
- in_data  input  W  upstream bundle.
- out_valid  output  1  main entry valid.
- out_ready  input  1  downstream accepts.
- out_data  output  W  main entry (or BUBBLE, per ZERO_BUBBLE).
- occupancy  output  2  number of valid entries, 0..2.
- stall_cnt  output  CNT_W  cycles with in_valid=1 and in_ready=0, saturating.
- stall_clr  input  1  synchronous clear of stall_cnt.

Behaviour:
- Transfer definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- Internal state: main_valid/main_data, skid_valid/skid_data.
- Derived outputs:
  - out_valid = main_valid.
  - in_ready = !skid_valid.
  - occupancy = main_valid + skid_valid.
- States: EMPTY (0 entries), BUSY (main only), FULL (main + skid). skid_valid=1 implies main_valid=1, always.
- EMPTY:
  - push -> main<=in_data; go to BUSY.
  - otherwise stay in EMPTY.
- BUSY:
  - push & pop -> main<=in_data; stay in BUSY.
  - push & !pop -> skid<=in_data; go to FULL.
  - !push & pop -> go to EMPTY.
  - otherwise hold.
- FULL (in_ready=0, so no push):
  - pop -> main<=skid_data, skid_valid<=0; go to BUSY.
  - otherwise hold both entries unchanged.
- Latency and throughput:
  - A bundle pushed in cycle t is visible on out_data/out_valid in cycle t+1.
  - Throughput is 1 bundle/cycle while out_ready=1.
  - Order is strictly FIFO; no bundle is duplicated or dropped except by flush.
- Flush (priority over push/pop):
  - Next cycle: main_valid=0, skid_valid=0, data registers=BUBBLE, state EMPTY, in_ready=1.
  - An in_data presented in the flush cycle is discarded, even if in_ready=1.
  - A pop in the flush cycle still counts as delivered to downstream; the stage takes no action on it.
- Reset (rst=1, checked before flush):
  - Next cycle: all valids 0, data registers=BUBBLE, stall_cnt=0, occupancy=0, out_valid=0, in_ready=1, out_data=BUBBLE.
  - Reset mid-transfer discards held entries.
- stall_cnt:
  - Increments by 1 in any cycle where in_valid=1 and in_ready=0.
  - Saturates at 2^CNT_W-1.
  - stall_clr=1 forces 0 next cycle, taking priority over increment.
  - flush does not affect it.
- Data registers are loaded only on the transitions listed above; no other writes.
- out_data must not combinationally depend on in_data or out_ready.

Test Plan:
1. Reset then stream, W=8, out_ready=1: push 0x11,0x22,0x33 on consecutive cycles.
   - out_data must be 0x11,0x22,0x33 in cycles t+1..t+3 with out_valid=1.
   - in_ready must stay 1 and occupancy=1 throughout.
2. Backpressure, out_ready=0: push 0xA1, then 0xA2.
   - Occupancy goes 1 then 2; in_ready=0; in_valid held with 0xA3 -> stall_cnt increments each cycle.
   - Raise out_ready: order out must be 0xA1,0xA2,0xA3, with no loss.
3. Flush in FULL state holding 0xB1/0xB2, with in_valid=1 carrying 0xB3 in the flush cycle.
   - Next cycle: out_valid=0, occupancy=0, out_data=0x00, in_ready=1.
   - 0xB3 must never appear on the output.
4. Simultaneous push and pop in BUSY holding 0xC1, pushing 0xC2: next cycle out_data=0xC2, occupancy=1, skid unused.
5. Saturation, CNT_W=4: hold stall condition for 20 cycles -> stall_cnt=15; then assert stall_clr -> stall_cnt=0 next cycle.
6. rst asserted while FULL and flush=1 simultaneously:
   - Next cycle: all outputs at reset values and stall_cnt=0.
   - Resumed stream 0xD1 is delivered at t+1.
